ooo_writeback_arbiter: RTL and testbench

OOO_WRITEBACK_ARBITER -- requirements
Module: ooo_writeback_arbiter

---
 rtl/ooo_writeback_arbiter_pkg.sv | 21 ++
 rtl/ooo_writeback_arbiter_rr_picker.sv | 30 +++
 rtl/ooo_writeback_arbiter.sv | 75 +++++++
 tb/tb_ooo_writeback_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ooo_writeback_arbiter_pkg.sv
// Shared OoO types: completion-buffer index width, FU ids and writeback packet.
package ooo_writeback_arbiter_pkg;

    localparam int CB_IDX_W = 4;
    localparam int NUM_FU   = 4;

    typedef enum logic [1:0] {
        AU_WB = 2'd0,
        MU_WB = 2'd1,
        DU_WB = 2'd2,
        LS_WB = 2'd3
    } fu_id_e;

    typedef struct packed {
        fu_id_e              fu;
        logic [CB_IDX_W-1:0] index;
        logic [31:0]         data;
        logic                exception;
    } wb_pkt_t;

endpackage

// File: rtl/ooo_writeback_arbiter_rr_picker.sv
// Round-robin picker: first requester at or after ptr, wrapping modulo 4.
module ooo_rr_picker
    import ooo_writeback_arbiter_pkg::*;
(
    input  logic [3:0] request,
    input  logic [1:0] ptr,
    output logic [3:0] grant,
    output logic [1:0] id,
    output logic       any
);

    logic [1:0] idx;

    // Scan the four FUs starting at ptr; the first requester wins.
    always_comb begin
        grant = '0;
        id    = '0;
        any   = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            idx = ptr + 2'(i);
            if (!any && request[idx]) begin
                grant[idx] = 1'b1;
                id         = idx;
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ooo_writeback_arbiter.sv
// Writeback arbiter: four FUs share one registered slot feeding the
// completion-buffer write port, with round-robin fairness.
module ooo_writeback_arbiter
    import ooo_writeback_arbiter_pkg::*;
#(
    parameter int CB_IDX_W = ooo_writeback_arbiter_pkg::CB_IDX_W
)(
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [3:0]            req_valid,
    input  logic [4*CB_IDX_W-1:0] req_index,
    input  logic [127:0]          req_data,
    input  logic [3:0]            req_exception,
    output logic [3:0]            req_ready,
    input  logic                  flush,
    input  logic                  wb_ready,
    output logic                  wb_valid,
    output logic [1:0]            wb_fu,
    output logic [CB_IDX_W-1:0]   wb_index,
    output logic [31:0]           wb_data,
    output logic                  wb_exception,
    output logic [3:0]            fu_stall
);

    logic       slot_full;
    logic [1:0] ptr;
    wb_pkt_t    pkt;

    logic [3:0] pick_grant;
    logic [1:0] pick_id;
    logic       pick_any;
    logic       loadable;
    logic       accept;

    ooo_rr_picker u_picker (
        .request (req_valid),
        .ptr     (ptr),
        .grant   (pick_grant),
        .id      (pick_id),
        .any     (pick_any)
    );

    // Reset is folded in so no FU sees an accept while the slot is held in reset.
    assign loadable  = nRST && !flush && (!slot_full || wb_ready);
    assign accept    = loadable && pick_any;
    assign req_ready = loadable ? pick_grant : 4'b0000;
    assign fu_stall  = nRST ? (req_valid & ~req_ready) : 4'b0000;

    // Slot state, contents and round-robin pointer; flush beats drain and load.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            slot_full <= 1'b0;
            ptr       <= 2'd0;
            pkt       <= '0;
        end else if (flush) begin
            slot_full <= 1'b0;
        end else if (accept) begin
            slot_full     <= 1'b1;
            ptr           <= pick_id + 2'd1;
            pkt.fu        <= fu_id_e'(pick_id);
            pkt.index     <= req_index[pick_id*CB_IDX_W +: CB_IDX_W];
            pkt.data      <= req_data[pick_id*32 +: 32];
            pkt.exception <= req_exception[pick_id];
        end else if (wb_ready) begin
            slot_full <= 1'b0;
        end
    end

    assign wb_valid     = slot_full;
    assign wb_fu        = pkt.fu;
    assign wb_index     = pkt.index;
    assign wb_data      = pkt.data;
    assign wb_exception = pkt.exception;

endmodule

// File: tb/tb_ooo_writeback_arbiter.sv
// Self-checking bench for ooo_writeback_arbiter: vector table plus directed
// corner sequences, with a monitor on the requester hold contract.
module tb_ooo_writeback_arbiter;
    import ooo_writeback_arbiter_pkg::*;

    logic                  CLK = 1'b0;
    logic                  nRST;
    logic [3:0]            req_valid;
    logic [4*CB_IDX_W-1:0] req_index;
    logic [127:0]          req_data;
    logic [3:0]            req_exception;
    logic [3:0]            req_ready;
    logic                  flush;
    logic                  wb_ready;
    logic                  wb_valid;
    logic [1:0]            wb_fu;
    logic [CB_IDX_W-1:0]   wb_index;
    logic [31:0]           wb_data;
    logic                  wb_exception;
    logic [3:0]            fu_stall;

    int checks   = 0;
    int failures = 0;

    ooo_writeback_arbiter dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .req_valid     (req_valid),
        .req_index     (req_index),
        .req_data      (req_data),
        .req_exception (req_exception),
        .req_ready     (req_ready),
        .flush         (flush),
        .wb_ready      (wb_ready),
        .wb_valid      (wb_valid),
        .wb_fu         (wb_fu),
        .wb_index      (wb_index),
        .wb_data       (wb_data),
        .wb_exception  (wb_exception),
        .fu_stall      (fu_stall)
    );

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [CB_IDX_W-1:0] def_idx(input int k);
        return CB_IDX_W'(k + 8);
    endfunction

    function automatic logic [31:0] def_data(input int k);
        return 32'hA000_0000 + 32'(k);
    endfunction

    function automatic logic def_exc(input int k);
        return (k == 2);
    endfunction

    task automatic set_defaults();
        for (int k = 0; k < 4; k++) begin
            req_index[k*CB_IDX_W +: CB_IDX_W] = def_idx(k);
            req_data[k*32 +: 32]              = def_data(k);
            req_exception[k]                  = def_exc(k);
        end
    endtask

    // Requester contract: a pending, unaccepted, unflushed request must persist unchanged.
    logic                  mon_en = 1'b0;
    logic [3:0]            hold_mask = 4'b0000;
    logic [4*CB_IDX_W-1:0] hold_index;
    logic [127:0]          hold_data;
    logic [3:0]            hold_exc;

    always @(posedge CLK) begin
        if (mon_en && nRST) begin
            for (int k = 0; k < 4; k++) begin
                if (hold_mask[k] && (!req_valid[k] ||
                    req_index[k*CB_IDX_W +: CB_IDX_W] !== hold_index[k*CB_IDX_W +: CB_IDX_W] ||
                    req_data[k*32 +: 32] !== hold_data[k*32 +: 32] ||
                    req_exception[k] !== hold_exc[k])) begin
                    failures++;
                    $display("FAIL contract fu=%0d dropped or changed before accept", k);
                end
            end
        end
        hold_mask  = nRST ? (req_valid & ~req_ready & ~{4{flush}}) : 4'b0000;
        hold_index = req_index;
        hold_data  = req_data;
        hold_exc   = req_exception;
    end

    typedef struct {
        logic [3:0] valid;
        logic       wbr;
        logic       fl;
        logic [3:0] exp_ready;
        logic [3:0] exp_stall;
        logic       exp_wv;
        logic [1:0] exp_fu;
        logic [1:0] exp_ptr;
    } vec_t;

    vec_t tbl[15];

    // Registered-output checks after an edge, against the expected slot contents.
    task automatic chk_slot(input string tag, input logic wv, input logic [1:0] fu,
                            input logic [CB_IDX_W-1:0] idx, input logic [31:0] data,
                            input logic exc);
        chk({tag, ".wb_valid"},     32'(wb_valid),     32'(wv));
        chk({tag, ".wb_fu"},        32'(wb_fu),        32'(fu));
        chk({tag, ".wb_index"},     32'(wb_index),     32'(idx));
        chk({tag, ".wb_data"},      wb_data,           data);
        chk({tag, ".wb_exception"}, 32'(wb_exception), 32'(exc));
    endtask

    task automatic chk_comb(input string tag, input logic [3:0] rdy, input logic [3:0] stl);
        chk({tag, ".req_ready"}, 32'(req_ready), 32'(rdy));
        chk({tag, ".fu_stall"},  32'(fu_stall),  32'(stl));
    endtask

    initial begin
        // valid  wbr fl  ready    stall    wv fu ptr
        tbl[0]  = '{4'b1111, 1, 0, 4'b0001, 4'b1110, 1, 0, 1};
        tbl[1]  = '{4'b1111, 1, 0, 4'b0010, 4'b1101, 1, 1, 2};
        tbl[2]  = '{4'b1111, 1, 0, 4'b0100, 4'b1011, 1, 2, 3};
        tbl[3]  = '{4'b1111, 1, 0, 4'b1000, 4'b0111, 1, 3, 0};
        tbl[4]  = '{4'b0111, 1, 0, 4'b0001, 4'b0110, 1, 0, 1};
        tbl[5]  = '{4'b0110, 1, 0, 4'b0010, 4'b0100, 1, 1, 2};
        tbl[6]  = '{4'b0100, 1, 0, 4'b0100, 4'b0000, 1, 2, 3};
        tbl[7]  = '{4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 2, 3};
        tbl[8]  = '{4'b0010, 0, 0, 4'b0010, 4'b0000, 1, 1, 2};
        tbl[9]  = '{4'b0101, 0, 0, 4'b0000, 4'b0101, 1, 1, 2};
        tbl[10] = '{4'b0101, 1, 0, 4'b0100, 4'b0001, 1, 2, 3};
        tbl[11] = '{4'b0001, 1, 0, 4'b0001, 4'b0000, 1, 0, 1};
        tbl[12] = '{4'b0000, 0, 0, 4'b0000, 4'b0000, 1, 0, 1};
        tbl[13] = '{4'b1000, 0, 1, 4'b0000, 4'b1000, 0, 0, 1};
        tbl[14] = '{4'b1000, 0, 0, 4'b1000, 4'b0000, 1, 3, 0};

        nRST      = 1'b0;
        req_valid = 4'b1111;
        flush     = 1'b0;
        wb_ready  = 1'b0;
        req_index = '0;
        req_data  = '0;
        req_exception = '0;
        set_defaults();

        #2;
        chk_comb("in_reset", 4'b0000, 4'b0000);
        chk("in_reset.wb_valid", 32'(wb_valid), 32'd0);

        @(negedge CLK);
        nRST      = 1'b1;
        req_valid = 4'b0000;
        #1;
        chk_comb("reset_release", 4'b0000, 4'b0000);
        chk_slot("reset_release", 1'b0, 2'd0, '0, 32'h0, 1'b0);
        chk("reset_release.ptr", 32'(dut.ptr), 32'd0);
        @(posedge CLK); #1;
        chk("idle.wb_valid", 32'(wb_valid), 32'd0);
        @(negedge CLK);
        mon_en = 1'b1;

        for (int i = 0; i < 15; i++) begin
            req_valid = tbl[i].valid;
            wb_ready  = tbl[i].wbr;
            flush     = tbl[i].fl;
            #1;
            chk_comb($sformatf("vec%0d", i), tbl[i].exp_ready, tbl[i].exp_stall);
            @(posedge CLK); #1;
            chk_slot($sformatf("vec%0d", i), tbl[i].exp_wv, tbl[i].exp_fu,
                     def_idx(int'(tbl[i].exp_fu)), def_data(int'(tbl[i].exp_fu)),
                     def_exc(int'(tbl[i].exp_fu)));
            chk($sformatf("vec%0d.ptr", i), 32'(dut.ptr), 32'(tbl[i].exp_ptr));
            @(negedge CLK);
        end

        // Drain, then LS accepted and held under backpressure.
        req_valid = 4'b0000; wb_ready = 1'b1; flush = 1'b0;
        @(posedge CLK); #1;
        chk("drain.wb_valid", 32'(wb_valid), 32'd0);
        @(negedge CLK);
        req_index[3*CB_IDX_W +: CB_IDX_W] = CB_IDX_W'(5);
        req_data[3*32 +: 32]              = 32'hDEAD_BEEF;
        req_exception[3]                  = 1'b0;
        req_valid = 4'b1000;
        #1;
        chk_comb("ls_accept", 4'b1000, 4'b0000);
        @(posedge CLK); #1;
        chk_slot("ls_accept", 1'b1, 2'd3, CB_IDX_W'(5), 32'hDEAD_BEEF, 1'b0);
        @(negedge CLK);
        req_valid = 4'b0011; wb_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk_comb($sformatf("bp%0d", c), 4'b0000, 4'b0011);
            @(posedge CLK); #1;
            chk_slot($sformatf("bp%0d", c), 1'b1, 2'd3, CB_IDX_W'(5), 32'hDEAD_BEEF, 1'b0);
            @(negedge CLK);
        end
        wb_ready = 1'b1;
        #1;
        chk_comb("bp_release", 4'b0001, 4'b0010);
        @(posedge CLK); #1;
        chk_slot("bp_release", 1'b1, 2'd0, def_idx(0), def_data(0), def_exc(0));
        chk("bp_release.ptr", 32'(dut.ptr), 32'd1);
        @(negedge CLK);
        req_valid = 4'b0010;
        #1;
        chk_comb("mu_follow", 4'b0010, 4'b0000);
        @(posedge CLK); #1;
        chk_slot("mu_follow", 1'b1, 2'd1, def_idx(1), def_data(1), def_exc(1));
        @(negedge CLK);

        // DU with exception and a custom index.
        req_index[2*CB_IDX_W +: CB_IDX_W] = CB_IDX_W'(3);
        req_exception[2]                  = 1'b1;
        req_valid = 4'b0100;
        #1;
        chk_comb("du_exc", 4'b0100, 4'b0000);
        @(posedge CLK); #1;
        chk_slot("du_exc", 1'b1, 2'd2, CB_IDX_W'(3), def_data(2), 1'b1);
        chk("du_exc.ptr", 32'(dut.ptr), 32'd3);
        @(negedge CLK);

        // Flush with the slot full: no grant, slot empties, pointer holds.
        flush = 1'b1; req_valid = 4'b0100; wb_ready = 1'b1;
        #1;
        chk_comb("flush", 4'b0000, 4'b0100);
        @(posedge CLK); #1;
        chk("flush.wb_valid", 32'(wb_valid), 32'd0);
        chk("flush.ptr", 32'(dut.ptr), 32'd3);
        @(negedge CLK);

        // Load the slot, then hit reset between edges.
        flush = 1'b0; req_valid = 4'b0001; wb_ready = 1'b1;
        set_defaults();
        #1;
        chk_comb("pre_reset_load", 4'b0001, 4'b0000);
        @(posedge CLK); #1;
        chk("pre_reset_load.wb_valid", 32'(wb_valid), 32'd1);
        chk("pre_reset_load.ptr", 32'(dut.ptr), 32'd1);
        @(negedge CLK);
        wb_ready = 1'b0;
        #2;
        nRST = 1'b0;
        #1;
        chk_slot("async_reset", 1'b0, 2'd0, '0, 32'h0, 1'b0);
        chk("async_reset.ptr", 32'(dut.ptr), 32'd0);
        chk_comb("async_reset", 4'b0000, 4'b0000);
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        chk_comb("post_reset", 4'b0001, 4'b0000);
        @(posedge CLK); #1;
        chk_slot("post_reset", 1'b1, 2'd0, def_idx(0), def_data(0), def_exc(0));
        @(negedge CLK);
        req_valid = 4'b0000;
        @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
